// File: rtl/port_bus_master_pkg.sv
// Shared types for the KCPSM3-style port bus master: FSM states and queued command layout.
package port_bus_master_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StStrobe = 2'd2,
        StResp   = 2'd3
    } state_e;

    // Queued command: {rw[16], port[15:8], data[7:0]}; rw = 1 means read.
    typedef struct packed {
        logic       rw;
        logic [7:0] port;
        logic [7:0] data;
    } cmd_t;

    localparam int unsigned CMD_W = $bits(cmd_t);

endpackage

// File: rtl/port_bus_master_fifo.sv
// Synchronous command FIFO, depth 2**AW, with full/empty flags.
// Simultaneous push and pop both take effect and leave the count unchanged.
module port_bus_master_fifo #(
    parameter int unsigned WIDTH = 17,
    parameter int unsigned AW    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;

    // Count never exceeds DEPTH, so its top bit alone marks full.
    assign full  = count_q[AW];
    assign empty = (count_q == '0);
    assign rdata = mem_q[rd_ptr_q];

    // Storage array: written on push only, contents are don't-care when empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Pointers and occupancy; reset discards anything queued.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/port_bus_master.sv
// Port bus initiator: queues {rw, port, data} commands and replays them as KCPSM3 bus cycles
// (one setup cycle, one strobe cycle), returning read data on a valid/ready channel.
module port_bus_master
    import port_bus_master_pkg::*;
#(
    parameter int unsigned FIFO_AW = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [7:0] cmd_port,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic [7:0] port_id,
    output logic [7:0] out_port,
    output logic       write_strobe,
    output logic       read_strobe,
    input  logic [7:0] in_port,
    output logic       busy
);

    state_e     state_q, state_d;
    cmd_t       fifo_head;
    logic       fifo_full, fifo_empty;
    logic       push, pop;
    logic       rw_q;
    logic [7:0] port_id_q, out_port_q, rsp_data_q;
    logic       write_strobe_q, read_strobe_q;

    // Ready is gated by reset so nothing is accepted while the block is held in reset.
    assign cmd_ready = reset & ~fifo_full;
    assign push      = cmd_valid & cmd_ready;

    port_bus_master_fifo #(
        .WIDTH (CMD_W),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata ({cmd_rw, cmd_port, cmd_data}),
        .pop   (pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next-state and pop decision; a pop always launches a new SETUP cycle.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                state_d = StStrobe;
            end
            StStrobe: begin
                if (rw_q) begin
                    state_d = StResp;
                end else if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = StSetup;
                end else begin
                    state_d = StIdle;
                end
            end
            StResp: begin
                // Bus stays quiet until the response is taken, so each read has one response.
                if (rsp_ready) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = StSetup;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, bus registers, registered strobes and read capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= StIdle;
            rw_q           <= 1'b0;
            port_id_q      <= '0;
            out_port_q     <= '0;
            write_strobe_q <= 1'b0;
            read_strobe_q  <= 1'b0;
            rsp_data_q     <= '0;
        end else begin
            state_q        <= state_d;
            // Strobe is only entered from SETUP, where rw_q is already the active command.
            write_strobe_q <= (state_d == StStrobe) && !rw_q;
            read_strobe_q  <= (state_d == StStrobe) && rw_q;
            if (pop) begin
                rw_q       <= fifo_head.rw;
                port_id_q  <= fifo_head.port;
                out_port_q <= fifo_head.data;
            end
            if ((state_q == StStrobe) && rw_q) begin
                rsp_data_q <= in_port;
            end
        end
    end

    assign port_id      = port_id_q;
    assign out_port     = out_port_q;
    assign write_strobe = write_strobe_q;
    assign read_strobe  = read_strobe_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_valid    = (state_q == StResp);
    assign busy         = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_port_bus_master.sv
// Bench for port_bus_master: table of single transactions plus hand-written multi-cycle sequences.
module tb_port_bus_master;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_rw = 1'b0;
    logic [7:0] cmd_port = '0;
    logic [7:0] cmd_data = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic [7:0] port_id;
    logic [7:0] out_port;
    logic       write_strobe;
    logic       read_strobe;
    logic [7:0] in_port_drv = '0;
    logic       busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    port_bus_master #(
        .FIFO_AW (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_rw       (cmd_rw),
        .cmd_port     (cmd_port),
        .cmd_data     (cmd_data),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .port_id      (port_id),
        .out_port     (out_port),
        .write_strobe (write_strobe),
        .read_strobe  (read_strobe),
        .in_port      (in_port_drv),
        .busy         (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Seven-segment style peripheral: four digit registers at ports 0..3.
    logic [7:0] seg [4];
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) seg[i] <= '0;
        end else if (write_strobe && (port_id < 8'd4)) begin
            seg[port_id[1:0]] <= out_port;
        end
    end

    // Bus event log, sampled on the falling edge.
    int         cyc = 0;
    int         ev_cyc [$];
    logic       ev_rw [$];
    logic [7:0] ev_port [$];
    logic [7:0] ev_data [$];
    logic       prev_stb = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (write_strobe || read_strobe) begin
            ev_cyc.push_back(cyc);
            ev_rw.push_back(read_strobe);
            ev_port.push_back(port_id);
            ev_data.push_back(out_port);
            check("strobe_excl", 32'(write_strobe & read_strobe), 0);
            check("strobe_width", 32'(prev_stb), 0);
        end
        prev_stb <= write_strobe | read_strobe;
    end

    task automatic clear_log();
        ev_cyc.delete();
        ev_rw.delete();
        ev_port.delete();
        ev_data.delete();
    endtask

    // Caller sits at a falling edge; returns at the falling edge after acceptance.
    task automatic push_cmd(input logic rw, input logic [7:0] port, input logic [7:0] data);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_rw    = rw;
        cmd_port  = port;
        cmd_data  = data;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("push_accept", 32'(cmd_ready), 1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string name);
        int n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(rsp_valid), 1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(busy), 0);
    endtask

    typedef struct {
        logic       rw;
        logic [7:0] port;
        logic [7:0] data;
        logic [7:0] in_data;
        logic [7:0] exp_rsp;
    } vec_t;

    vec_t vecs [6];

    // One isolated transaction, checked cycle by cycle from acceptance edge E.
    task automatic run_vec(input vec_t v);
        in_port_drv = v.in_data;
        rsp_ready   = 1'b0;
        cmd_valid   = 1'b1;
        cmd_rw      = v.rw;
        cmd_port    = v.port;
        cmd_data    = v.data;
        check("v_ready", 32'(cmd_ready), 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("v_queued_busy", 32'(busy), 1);
        check("v_queued_stb", 32'({write_strobe, read_strobe}), 0);
        @(negedge clk);
        check("v_setup_port", 32'(port_id), 32'(v.port));
        if (!v.rw) check("v_setup_out", 32'(out_port), 32'(v.data));
        check("v_setup_stb", 32'({write_strobe, read_strobe}), 0);
        @(negedge clk);
        check("v_strobe_port", 32'(port_id), 32'(v.port));
        if (!v.rw) check("v_strobe_out", 32'(out_port), 32'(v.data));
        check("v_strobe_w", 32'(write_strobe), 32'(!v.rw));
        check("v_strobe_r", 32'(read_strobe), 32'(v.rw));
        @(negedge clk);
        check("v_after_stb", 32'({write_strobe, read_strobe}), 0);
        if (v.rw) begin
            check("v_rsp_valid", 32'(rsp_valid), 1);
            check("v_rsp_data", 32'(rsp_data), 32'(v.exp_rsp));
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            check("v_rsp_drop", 32'(rsp_valid), 0);
        end
        check("v_done_busy", 32'(busy), 0);
        check("v_hold_port", 32'(port_id), 32'(v.port));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int rel;
        int n;

        vecs[0] = '{1'b0, 8'h02, 8'hA5, 8'h00, 8'h00};
        vecs[1] = '{1'b1, 8'h01, 8'h00, 8'h3C, 8'h3C};
        vecs[2] = '{1'b0, 8'hFF, 8'h5A, 8'h00, 8'h00};
        vecs[3] = '{1'b1, 8'h80, 8'h00, 8'hC3, 8'hC3};
        vecs[4] = '{1'b0, 8'h00, 8'hFF, 8'h00, 8'h00};
        vecs[5] = '{1'b1, 8'hFF, 8'h00, 8'h00, 8'h00};

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_port_id", 32'(port_id), 0);
        check("rst_out_port", 32'(out_port), 0);
        check("rst_strobes", 32'({write_strobe, read_strobe}), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_data", 32'(rsp_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_cmd_ready", 32'(cmd_ready), 0);
        reset = 1'b1;
        @(negedge clk);
        check("rel_cmd_ready", 32'(cmd_ready), 1);

        // Table of isolated transactions.
        for (int i = 0; i < 6; i++) run_vec(vecs[i]);
        check("seg_digit2", 32'(seg[2]), 32'h A5);
        check("seg_digit0", 32'(seg[0]), 32'h FF);

        // Read parked in RESP while writes fill the FIFO; then five writes every 2 cycles.
        clear_log();
        in_port_drv = 8'h55;
        rsp_ready   = 1'b0;
        push_cmd(1'b1, 8'h10, 8'h00);
        wait_rsp("t3_rsp");
        for (int i = 0; i < 4; i++) push_cmd(1'b0, 8'(32'h20 + i), 8'(32'h30 + i));
        check("t3_full_ready", 32'(cmd_ready), 0);
        repeat (2) @(negedge clk);
        check("t3_hold_ready", 32'(cmd_ready), 0);
        check("t3_no_bus", 32'(ev_cyc.size()), 1);
        check("t3_rsp_data", 32'(rsp_data), 32'h55);
        rsp_ready = 1'b1;
        push_cmd(1'b0, 8'h24, 8'h34);
        rsp_ready = 1'b0;
        wait_idle("t3_idle");
        check("t3_events", 32'(ev_cyc.size()), 6);
        if (ev_cyc.size() == 6) begin
            check("t3_rd_rw", 32'(ev_rw[0]), 1);
            check("t3_rd_port", 32'(ev_port[0]), 32'h10);
            for (int i = 0; i < 5; i++) begin
                check("t3_wr_rw", 32'(ev_rw[i+1]), 0);
                check("t3_wr_port", 32'(ev_port[i+1]), 32'h20 + i);
                check("t3_wr_data", 32'(ev_data[i+1]), 32'h30 + i);
                if (i > 0) check("t3_wr_spacing", 32'(ev_cyc[i+1] - ev_cyc[i]), 2);
            end
        end

        // Stalled response with a write queued behind it.
        clear_log();
        in_port_drv = 8'h81;
        rsp_ready   = 1'b0;
        push_cmd(1'b1, 8'h00, 8'h00);
        push_cmd(1'b0, 8'h07, 8'h99);
        wait_rsp("t4_rsp");
        repeat (5) @(negedge clk);
        check("t4_rsp_held", 32'(rsp_valid), 1);
        check("t4_rsp_data", 32'(rsp_data), 32'h81);
        check("t4_one_read", 32'(ev_cyc.size()), 1);
        rel = cyc;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("t4_rsp_drop", 32'(rsp_valid), 0);
        check("t4_setup_port", 32'(port_id), 32'h07);
        check("t4_setup_out", 32'(out_port), 32'h99);
        check("t4_setup_stb", 32'(write_strobe), 0);
        @(negedge clk);
        check("t4_wr_strobe", 32'(write_strobe), 1);
        wait_idle("t4_idle");
        check("t4_events", 32'(ev_cyc.size()), 2);
        if (ev_cyc.size() == 2) begin
            check("t4_ev_rd", 32'(ev_rw[0]), 1);
            check("t4_ev_wr", 32'(ev_rw[1]), 0);
            check("t4_wr_cycle", 32'(ev_cyc[1]), 32'(rel + 2));
        end

        // Asynchronous reset during a write strobe with three commands still queued.
        clear_log();
        in_port_drv = 8'h00;
        rsp_ready   = 1'b0;
        push_cmd(1'b1, 8'h11, 8'h00);
        wait_rsp("t5_rsp");
        for (int i = 0; i < 4; i++) push_cmd(1'b0, 8'(32'h40 + i), 8'(32'h50 + i));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        @(negedge clk);
        check("t5_strobe", 32'(write_strobe), 1);
        check("t5_port", 32'(port_id), 32'h40);
        #1 reset = 1'b0;
        #1;
        check("t5_async_wstb", 32'(write_strobe), 0);
        check("t5_async_port", 32'(port_id), 0);
        check("t5_async_busy", 32'(busy), 0);
        check("t5_async_ready", 32'(cmd_ready), 0);
        check("t5_async_rsp", 32'(rsp_valid), 0);
        n = ev_cyc.size();
        @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        check("t5_post_busy", 32'(busy), 0);
        check("t5_post_events", 32'(ev_cyc.size()), 32'(n));
        check("t5_post_ready", 32'(cmd_ready), 1);
        check("t5_post_port", 32'(port_id), 0);

        // Read then write to the same port.
        clear_log();
        in_port_drv = 8'h11;
        rsp_ready   = 1'b1;
        push_cmd(1'b1, 8'h05, 8'h00);
        push_cmd(1'b0, 8'h05, 8'hEE);
        n = 0;
        while (!write_strobe && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t6_wr_seen", 32'(write_strobe), 1);
        in_port_drv = 8'hEE;
        wait_idle("t6_idle");
        rsp_ready = 1'b0;
        check("t6_rsp_data", 32'(rsp_data), 32'h11);
        check("t6_rsp_valid", 32'(rsp_valid), 0);
        check("t6_events", 32'(ev_cyc.size()), 2);
        if (ev_cyc.size() == 2) begin
            check("t6_ev_rd", 32'(ev_rw[0]), 1);
            check("t6_ev_wr", 32'(ev_rw[1]), 0);
            check("t6_order", 32'(ev_cyc[1] > ev_cyc[0]), 1);
            check("t6_wr_data", 32'(ev_data[1]), 32'hEE);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
